alu_ctrl_decoder: RTL and testbench
===================================

Name: alu_ctrl_decoder

Overview:
- Decodes RV32I instruction words into the control bundle consumed by the core's ALU (ALU_op, a_n, b_n) plus operand-select, immediate and datapath-enable fields.
- Sits between the fetch/instruction register and execute, so it is the producing end of the ALU control interface.
- Uses valid/ready handshakes on both sides and a 2-entry skid buffer, so execute stalls never drop or duplicate an instruction and throughput stays at one per cycle.

Parameters:
XLEN, 32, data/immediate width (only 32 supported)
DEPTH, 2, skid-buffer entries (fixed at 2; sets output-path buffering)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instr/pc valid
in_ready  output  1  decoder can accept this cycle
instr  input  32  instruction word
pc  input  32  instruction address
out_valid  output  1  decoded bundle valid
out_ready  input  1  execute accepts bundle
alu_op  output  4  ALU operation code
a_n  output  1  invert ALU operand A
b_n  output  1  invert ALU operand B
src_a_sel  output  2  0=rs1, 1=pc, 2=zero
src_b_sel  output  1  0=rs2, 1=imm
imm  output  32  sign-extended immediate
rd, rs1, rs2  output  5 each  register indices
reg_wr  output  1  write rd
mem_rd  output  1  load
mem_wr  output  1  store
is_branch  output  1  conditional branch (ALU result bit0 = taken)
is_jump  output  1  JAL/JALR
illegal  output  1  unsupported encoding
pc_out  output  32  pc passed through

Behaviour:
- Reset: all outputs 0, buffer empty, in_ready=1 one cycle after rst_n deasserts. Reset asserted mid-transfer discards all buffered entries.
- Decode is combinational on instr/pc. The result is written into the buffer on an input handshake (in_valid & in_ready). Latency is 1 cycle: an instruction accepted at edge N has out_valid high after edge N.
- Outputs are driven only from the buffer head. All fields are held stable while out_valid & !out_ready.
- in_ready = (entries < 2), registered. A simultaneous push and pop leaves the count unchanged.
- Entry count 0 -> 1 -> 2 on push-only; 2 -> 1 -> 0 on pop-only.
- in_valid is ignored when in_ready=0. out_valid=0 whenever the buffer is empty.
- ALU encodings: AND 0000, OR 0001, XOR 0010, ADD/SUB 0011, LT 0100, GE 0101, EQ 0110, NE 0111, SLL 1000, SRL 1001, SRA 1010, LTU 1011, GEU 1100.
- Subtraction and compares are computed as A + ~B + 1, so b_n=1 for SUB, SLT/SLTI, SLTU/SLTIU, all branches. b_n=0 otherwise. a_n is always 0.
- OP (0110011): funct3/funct7 select op. funct7=0100000 is valid only for SUB and SRA.
- OP-IMM (0010011): same mapping, src_b_sel=1. Shifts: imm = zero-extended shamt[4:0]; illegal if funct7 is not 0000000 (or 0100000 for SRAI).
- LOAD/STORE: alu_op=0011, src_b_sel=1, mem_rd/mem_wr set. LOAD sets reg_wr.
- BRANCH: funct3 000/001/100/101/110/111 -> EQ/NE/LT/GE/LTU/GEU; src_b_sel=0; imm is the B-type immediate.
- LUI: src_a_sel=2, ADD, imm = U-type.
- AUIPC: src_a_sel=1, ADD, imm = U-type.
- JAL: src_a_sel=1, ADD, imm=4, is_jump=1, reg_wr=1.
- JALR: funct3 must be 000; src_a_sel=0, ADD, imm = I-type, is_jump=1, reg_wr=1.
- Any other opcode or funct combination: illegal=1, every enable 0, alu_op=0011, the entry still flows through the handshake.
- reg_wr is forced 0 when rd=0.

Decomposition:
- Shared package rv_pkg: ALU_op localparams (the 13 codes above), opcode constants, src-sel enums, decoded-bundle packed struct.
- Sub-module rv_imm_gen (combinational, I/S/B/U/J immediate extraction).
- The skid buffer stays inline.

Test Plan:
- 0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, alu_op=0011, b_n=0, rd=3, reg_wr=1, src_b_sel=0.
- 0x402081B3 (sub) -> alu_op=0011, b_n=1. 0x0020D463 (bge x1,x2,+8) -> alu_op=0101, b_n=1, is_branch=1, imm=0x00000008, reg_wr=0.
- 0x40335293 (srai x5,x6,3) -> alu_op=1010, src_b_sel=1, imm=0x00000003. Same with funct7=0x01 -> illegal=1.
- Stream 4 instrs with in_valid=1 and out_ready held 0 -> in_ready drops after 2 accepts. Release out_ready -> exactly 4 bundles out, in order, none duplicated.
- Assert rst_n=0 with 2 entries buffered -> out_valid=0 immediately, all outputs 0. After release -> in_ready=1, no stale bundle emitted.
- 0x00000000 -> illegal=1, reg_wr=mem_rd=mem_wr=0, handshake completes.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: ALU codes,
// opcodes, operand selects and the decoded bundle.
package rv_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_LT  = 4'b0100;
  localparam logic [3:0] ALU_GE  = 4'b0101;
  localparam logic [3:0] ALU_EQ  = 4'b0110;
  localparam logic [3:0] ALU_NE  = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_LTU = 4'b1011;
  localparam logic [3:0] ALU_GEU = 4'b1100;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_PC   = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_e;

  typedef enum logic {
    SRC_B_RS2 = 1'b0,
    SRC_B_IMM = 1'b1
  } src_b_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_SHAMT,
    IMM_FOUR
  } imm_sel_e;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        a_n;
    logic        b_n;
    src_a_e      src_a;
    src_b_e      src_b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
    logic [31:0] pc;
  } dec_t;

  // OP / OP-IMM funct3 to ALU code (SRA chosen by funct7)
  function automatic logic [3:0] alu_of_f3(
    input logic [2:0] f3
  );
    logic [3:0] r;
    unique case (f3)
      3'b000:  r = ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_LT;
      3'b011:  r = ALU_LTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate extraction for the RV32I formats,
// plus zero-extended shamt and the constant 4.
module rv_imm_gen
  import rv_pkg::*;
(
  input  logic [31:7] ins_i,
  input  imm_sel_e    sel_i,
  output logic [31:0] imm_o
);

  // format mux, defaulting to zero
  always_comb begin
    imm_o = '0;
    case (sel_i)
      IMM_NONE:  imm_o = '0;
      IMM_I:     imm_o = {{20{ins_i[31]}},
                          ins_i[31:20]};
      IMM_S:     imm_o = {{20{ins_i[31]}},
                          ins_i[31:25],
                          ins_i[11:7]};
      IMM_B:     imm_o = {{19{ins_i[31]}},
                          ins_i[31], ins_i[7],
                          ins_i[30:25],
                          ins_i[11:8], 1'b0};
      IMM_U:     imm_o = {ins_i[31:12], 12'b0};
      IMM_J:     imm_o = {{11{ins_i[31]}},
                          ins_i[31],
                          ins_i[19:12],
                          ins_i[20],
                          ins_i[30:21], 1'b0};
      IMM_SHAMT: imm_o = {27'b0, ins_i[24:20]};
      IMM_FOUR:  imm_o = 32'd4;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// RV32I to ALU-control decoder with a 2-entry
// skid buffer between fetch and execute.
module alu_ctrl_decoder
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic            a_n,
  output logic            b_n,
  output logic [1:0]      src_a_sel,
  output logic            src_b_sel,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            reg_wr,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            is_branch,
  output logic            is_jump,
  output logic            illegal,
  output logic [XLEN-1:0] pc_out
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        slt;
  logic        ill;
  imm_sel_e    isel;
  logic [31:0] imm_w;
  dec_t        ctl;
  dec_t        dec;

  assign op  = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign slt = (f3 == 3'b010) | (f3 == 3'b011);

  rv_imm_gen u_imm (
    .ins_i (instr[31:7]),
    .sel_i (isel),
    .imm_o (imm_w)
  );

  // control-field decode; illegal entries are scrubbed
  always_comb begin
    ctl        = '0;
    ctl.alu_op = ALU_ADD;
    ctl.src_a  = SRC_A_RS1;
    ctl.src_b  = SRC_B_RS2;
    ctl.rd     = instr[11:7];
    ctl.rs1    = instr[19:15];
    ctl.rs2    = instr[24:20];
    ctl.pc     = pc;
    isel       = IMM_NONE;
    ill        = 1'b0;
    unique case (op)
      OPC_OP: begin
        ctl.reg_wr = 1'b1;
        ctl.alu_op = alu_of_f3(f3);
        ctl.b_n    = slt;
        if (f7 == F7_ALT) begin
          if (f3 == 3'b000)
            ctl.b_n = 1'b1;
          else if (f3 == 3'b101)
            ctl.alu_op = ALU_SRA;
          else
            ill = 1'b1;
        end else if (f7 != F7_BASE) begin
          ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        ctl.reg_wr = 1'b1;
        ctl.src_b  = SRC_B_IMM;
        ctl.alu_op = alu_of_f3(f3);
        ctl.b_n    = slt;
        isel       = IMM_I;
        if (f3[1:0] == 2'b01) begin
          isel = IMM_SHAMT;
          if (f7 == F7_ALT && f3[2])
            ctl.alu_op = ALU_SRA;
          else if (f7 != F7_BASE)
            ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        ctl.reg_wr = 1'b1;
        ctl.mem_rd = 1'b1;
        ctl.src_b  = SRC_B_IMM;
        isel       = IMM_I;
        ill = (f3 == 3'b011) | (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        ctl.mem_wr = 1'b1;
        ctl.src_b  = SRC_B_IMM;
        isel       = IMM_S;
        ill = f3[2] | (f3[1:0] == 2'b11);
      end
      OPC_BRANCH: begin
        ctl.is_branch = 1'b1;
        ctl.b_n       = 1'b1;
        isel          = IMM_B;
        unique case (f3)
          3'b000:  ctl.alu_op = ALU_EQ;
          3'b001:  ctl.alu_op = ALU_NE;
          3'b100:  ctl.alu_op = ALU_LT;
          3'b101:  ctl.alu_op = ALU_GE;
          3'b110:  ctl.alu_op = ALU_LTU;
          3'b111:  ctl.alu_op = ALU_GEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LUI: begin
        ctl.reg_wr = 1'b1;
        ctl.src_a  = SRC_A_ZERO;
        ctl.src_b  = SRC_B_IMM;
        isel       = IMM_U;
      end
      OPC_AUIPC: begin
        ctl.reg_wr = 1'b1;
        ctl.src_a  = SRC_A_PC;
        ctl.src_b  = SRC_B_IMM;
        isel       = IMM_U;
      end
      OPC_JAL: begin
        ctl.reg_wr  = 1'b1;
        ctl.is_jump = 1'b1;
        ctl.src_a   = SRC_A_PC;
        ctl.src_b   = SRC_B_IMM;
        isel        = IMM_FOUR;
      end
      OPC_JALR: begin
        ctl.reg_wr  = 1'b1;
        ctl.is_jump = 1'b1;
        ctl.src_b   = SRC_B_IMM;
        isel        = IMM_I;
        ill         = (f3 != 3'b000);
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      ctl.alu_op    = ALU_ADD;
      ctl.b_n       = 1'b0;
      ctl.src_a     = SRC_A_RS1;
      ctl.src_b     = SRC_B_RS2;
      ctl.reg_wr    = 1'b0;
      ctl.mem_rd    = 1'b0;
      ctl.mem_wr    = 1'b0;
      ctl.is_branch = 1'b0;
      ctl.is_jump   = 1'b0;
      isel          = IMM_NONE;
    end
    ctl.illegal = ill;
    if (ctl.rd == 5'd0)
      ctl.reg_wr = 1'b0;
  end

  // merge the immediate into the bundle
  always_comb begin
    dec     = ctl;
    dec.imm = imm_w;
  end

  dec_t       mem_q [DEPTH];
  logic       wp_q;
  logic       rp_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       rdy_q;
  logic       push;
  logic       pop;
  dec_t       ob;

  assign out_valid = (cnt_q != 2'd0);
  assign in_ready  = rdy_q;
  assign push      = in_valid & rdy_q;
  assign pop       = out_valid & out_ready;

  // occupancy after this cycle's push/pop
  always_comb begin
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  // skid storage, pointers and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d < 2'(DEPTH));
      if (push) begin
        mem_q[wp_q] <= dec;
        wp_q        <= ~wp_q;
      end
      if (pop)
        rp_q <= ~rp_q;
    end
  end

  // head entry, zeroed while empty
  always_comb begin
    ob = out_valid ? mem_q[rp_q] : '0;
  end

  assign alu_op    = ob.alu_op;
  assign a_n       = ob.a_n;
  assign b_n       = ob.b_n;
  assign src_a_sel = ob.src_a;
  assign src_b_sel = ob.src_b;
  assign imm       = ob.imm;
  assign rd        = ob.rd;
  assign rs1       = ob.rs1;
  assign rs2       = ob.rs2;
  assign reg_wr    = ob.reg_wr;
  assign mem_rd    = ob.mem_rd;
  assign mem_wr    = ob.mem_wr;
  assign is_branch = ob.is_branch;
  assign is_jump   = ob.is_jump;
  assign illegal   = ob.illegal;
  assign pc_out    = ob.pc;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Bench for alu_ctrl_decoder: queue-based decode
// model checked every cycle plus directed literals.
module tb_alu_ctrl_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic        a_n;
  logic        b_n;
  logic [1:0]  src_a_sel;
  logic        src_b_sel;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        reg_wr;
  logic        mem_rd;
  logic        mem_wr;
  logic        is_branch;
  logic        is_jump;
  logic        illegal;
  logic [31:0] pc_out;

  int checks   = 0;
  int failures = 0;
  int pushes   = 0;
  int pops     = 0;

  always #5 clk = ~clk;

  alu_ctrl_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .a_n       (a_n),
    .b_n       (b_n),
    .src_a_sel (src_a_sel),
    .src_b_sel (src_b_sel),
    .imm       (imm),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .reg_wr    (reg_wr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .illegal   (illegal),
    .pc_out    (pc_out)
  );

  task automatic chk(
    input string        nm,
    input logic [127:0] a,
    input logic [127:0] e
  );
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h",
               nm, a, e);
    end
  endtask

  // Bundle layout (MSB first): alu[93:90] a_n[89]
  // b_n[88] sa[87:86] sb[85] imm[84:53] rd[52:48]
  // rs1[47:43] rs2[42:38] wr mr mw br jp il [37:32]
  // pc[31:0]
  function automatic logic [93:0] model(
    input logic [31:0] i,
    input logic [31:0] p
  );
    int op, f3, f7;
    int alu, sa;
    bit bn, sb, wr, mr, mw, br, jp, il;
    logic [31:0] im, ii, is, ib, iu;
    int optab [8] = '{3, 8, 4, 11, 2, 9, 1, 0};
    int brtab [8] = '{6, 7, -1, -1, 4, 5, 11, 12};
    op = int'(i[6:0]);
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    ii = 32'($signed(i[31:20]));
    is = 32'($signed({i[31:25], i[11:7]}));
    ib = 32'($signed({i[31], i[7], i[30:25],
                      i[11:8], 1'b0}));
    iu = i & 32'hFFFF_F000;
    alu = 3; sa = 0; im = 0;
    bn = 0; sb = 0; wr = 0; mr = 0;
    mw = 0; br = 0; jp = 0; il = 0;
    case (op)
      'h33: begin
        wr = 1; alu = optab[f3];
        bn = (f3 == 2 || f3 == 3);
        if (f7 == 'h20) begin
          if (f3 == 0) bn = 1;
          else if (f3 == 5) alu = 10;
          else il = 1;
        end else if (f7 != 0) il = 1;
      end
      'h13: begin
        wr = 1; sb = 1; alu = optab[f3];
        bn = (f3 == 2 || f3 == 3);
        if (f3 == 1 || f3 == 5) begin
          im = 32'(i[24:20]);
          if (f7 == 'h20 && f3 == 5) alu = 10;
          else if (f7 != 0) il = 1;
        end else im = ii;
      end
      'h03: begin
        wr = 1; mr = 1; sb = 1; im = ii;
        il = !(f3 == 0 || f3 == 1 || f3 == 2 ||
               f3 == 4 || f3 == 5);
      end
      'h23: begin
        mw = 1; sb = 1; im = is;
        il = (f3 > 2);
      end
      'h63: begin
        br = 1; bn = 1; im = ib;
        if (brtab[f3] < 0) il = 1;
        else alu = brtab[f3];
      end
      'h37: begin wr = 1; sa = 2; sb = 1; im = iu; end
      'h17: begin wr = 1; sa = 1; sb = 1; im = iu; end
      'h6F: begin
        wr = 1; jp = 1; sa = 1; sb = 1; im = 4;
      end
      'h67: begin
        wr = 1; jp = 1; sb = 1; im = ii;
        il = (f3 != 0);
      end
      default: il = 1;
    endcase
    if (il) begin
      alu = 3; bn = 0; sa = 0; sb = 0; im = 0;
      wr = 0; mr = 0; mw = 0; br = 0; jp = 0;
    end
    if (i[11:7] == 0) wr = 0;
    return {4'(alu), 1'b0, bn, 2'(sa), sb, im,
            i[11:7], i[19:15], i[24:20],
            wr, mr, mw, br, jp, il, p};
  endfunction

  logic [93:0] q [$];
  logic [93:0] act;
  bit          rdy_exp = 0;
  bit          m_push;
  bit          m_pop;

  // per-cycle compare against the queue model
  always @(negedge clk) begin
    act = {alu_op, a_n, b_n, src_a_sel, src_b_sel,
           imm, rd, rs1, rs2, reg_wr, mem_rd,
           mem_wr, is_branch, is_jump, illegal,
           pc_out};
    if (!rst_n) begin
      chk("rst_bundle", 128'(act), 128'(0));
      chk("rst_vld", 128'(out_valid), 128'(0));
      chk("rst_rdy", 128'(in_ready), 128'(0));
      q.delete();
      rdy_exp = 1;
    end else begin
      chk("rdy", 128'(in_ready), 128'(rdy_exp));
      chk("vld", 128'(out_valid),
          128'(q.size() != 0));
      if (q.size() != 0)
        chk("bundle", 128'(act), 128'(q[0]));
      m_push = in_valid && rdy_exp;
      m_pop  = out_ready && (q.size() != 0);
      if (m_pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (m_push) begin
        q.push_back(model(instr, pc_in));
        pushes++;
      end
      rdy_exp = (q.size() < 2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // called at posedge+1; returns at posedge+1
  // just after the accepting edge
  task automatic send(
    input logic [31:0] ins,
    input logic [31:0] p
  );
    int n;
    n = 0;
    instr    = ins;
    pc_in    = p;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("send_rdy", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [31:0] vec [20] = '{
    32'h00A00093, 32'h0020A133, 32'h123452B7,
    32'h00001517, 32'h008000EF, 32'h000080E7,
    32'h000090E7, 32'h0040A183, 32'h0040B183,
    32'h0030A223, 32'h0030B223, 32'hFE20CEE3,
    32'h0020A463, 32'h002091B3, 32'h0020F1B3,
    32'hFFF0B193, 32'h40109193, 32'h4020C1B3,
    32'h00208033, 32'h0000007F
  };

  logic [93:0] m;
  int p0;
  int r0;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    pc_in     = '0;
    out_ready = 1'b0;

    m = model(32'h0020D463, 32'h0);
    chk("pin_bge",
        128'({m[93:90], m[88], m[84:53],
              m[37], m[34]}),
        128'({4'b0101, 1'b1, 32'h8, 1'b0, 1'b1}));
    m = model(32'h40335293, 32'h0);
    chk("pin_srai",
        128'({m[93:90], m[85], m[84:53]}),
        128'({4'b1010, 1'b1, 32'h3}));
    m = model(32'h00000000, 32'h0);
    chk("pin_zero",
        128'({m[93:90], m[37:32]}),
        128'({4'b0011, 6'b000001}));

    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rdy_after_rst", 128'(in_ready), 128'(1));
    chk("vld_after_rst", 128'(out_valid), 128'(0));

    out_ready = 1'b1;
    send(32'h002081B3, 32'h100);
    @(negedge clk);
    chk("add_vld", 128'(out_valid), 128'(1));
    chk("add",
        128'({alu_op, b_n, rd, reg_wr, src_b_sel}),
        128'({4'b0011, 1'b0, 5'd3, 1'b1, 1'b0}));
    step();

    send(32'h402081B3, 32'h104);
    @(negedge clk);
    chk("sub", 128'({alu_op, b_n}),
        128'({4'b0011, 1'b1}));
    step();

    send(32'h0020D463, 32'h108);
    @(negedge clk);
    chk("bge",
        128'({alu_op, b_n, is_branch, imm, reg_wr}),
        128'({4'b0101, 1'b1, 1'b1, 32'h8, 1'b0}));
    step();

    send(32'h40335293, 32'h10C);
    @(negedge clk);
    chk("srai", 128'({alu_op, src_b_sel, imm}),
        128'({4'b1010, 1'b1, 32'h3}));
    step();

    send(32'h02335293, 32'h110);
    @(negedge clk);
    chk("srai_bad", 128'(illegal), 128'(1));
    step();

    send(32'h00000000, 32'h114);
    @(negedge clk);
    chk("zero",
        128'({out_valid, illegal, reg_wr,
              mem_rd, mem_wr}),
        128'(5'b11000));
    step();

    for (int i = 0; i < 20; i++)
      send(vec[i], 32'h1000 + 32'(4 * i));
    repeat (3) step();

    out_ready = 1'b0;
    p0 = pushes;
    r0 = pops;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(vec[i + 2], 32'h2000 + 32'(4 * i));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("full_rdy", 128'(in_ready), 128'(0));
        chk("full_cnt", 128'(pushes - p0),
            128'(2));
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    chk("stream_in", 128'(pushes - p0), 128'(4));
    chk("stream_out", 128'(pops - r0), 128'(4));

    out_ready = 1'b0;
    send(32'h002081B3, 32'h3000);
    send(32'h402081B3, 32'h3004);
    chk("pre_rst_rdy", 128'(in_ready), 128'(0));
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", 128'(out_valid), 128'(0));
    chk("mrst_out",
        128'({alu_op, b_n, imm, rd, reg_wr,
              pc_out, in_ready}),
        128'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_rdy", 128'(in_ready), 128'(1));
    chk("post_rst_vld", 128'(out_valid), 128'(0));
    out_ready = 1'b1;
    repeat (3) step();
    chk("no_stale", 128'(out_valid), 128'(0));

    send(32'h00C0006F, 32'h4000);
    repeat (3) step();
    chk("q_empty", 128'(q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
